// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply, restoring divide, one bit per cycle.
// Optional build macro MULDIV_FAST_MUL_EN: all multiplies finish in a single cycle.
module muldiv_unit #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [2:0]            MulCtrl,
    input  logic [DATA_WIDTH-1:0] SrcA,
    input  logic [DATA_WIDTH-1:0] SrcB,
    input  logic                  kill,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] Result
);

    localparam int W  = DATA_WIDTH;
    localparam int CW = (W > 1) ? $clog2(W) : 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [W-1:0]  MIN_VAL  = {1'b1, {(W-1){1'b0}}};
    localparam logic [CW-1:0] LAST_CNT = CW'(W - 1);

    function automatic logic [W-1:0] neg_if(input logic [W-1:0] v, input logic n);
        return n ? (~v + 1'b1) : v;
    endfunction

    function automatic logic [2*W-1:0] neg2_if(input logic [2*W-1:0] v, input logic n);
        return n ? (~v + 1'b1) : v;
    endfunction

    logic [1:0]     state_q, state_d;
    logic [2:0]     op_q, op_d;
    logic [W-1:0]   opnd_q, opnd_d;
    logic [2*W-1:0] acc_q, acc_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           neg_q, neg_d;
    logic [W-1:0]   res_q, res_d;

    // Operand decode on the start edge: MULHU/DIVU/REMU treat SrcA as unsigned,
    // MULHSU/MULHU/DIVU/REMU treat SrcB as unsigned.
    logic           sgn_a_en, sgn_b_en, a_neg, b_neg, start_neg;
    logic [W-1:0]   mag_a, mag_b;
    logic           div_zero, div_ovf, direct;
    logic [W-1:0]   special_res, direct_res;

    always_comb begin
        sgn_a_en  = !(MulCtrl == 3'b011 || MulCtrl == 3'b101 || MulCtrl == 3'b111);
        sgn_b_en  = !(MulCtrl == 3'b010 || MulCtrl == 3'b011 ||
                      MulCtrl == 3'b101 || MulCtrl == 3'b111);
        a_neg     = sgn_a_en & SrcA[W-1];
        b_neg     = sgn_b_en & SrcB[W-1];
        mag_a     = neg_if(SrcA, a_neg);
        mag_b     = neg_if(SrcB, b_neg);
        start_neg = (MulCtrl[2] & MulCtrl[1]) ? a_neg : (a_neg ^ b_neg);
        div_zero  = MulCtrl[2] & (SrcB == '0);
        div_ovf   = MulCtrl[2] & ~MulCtrl[0] & (SrcA == MIN_VAL) & (SrcB == '1);
        if (div_zero)
            special_res = MulCtrl[1] ? SrcA : '1;
        else
            special_res = MulCtrl[1] ? '0 : MIN_VAL;
    end

`ifdef MULDIV_FAST_MUL_EN
    // Sign-extended operands multiplied modulo 2^(2W) give the exact signed/unsigned product.
    logic [2*W-1:0] fa, fb, fprod;
    logic [W-1:0]   fast_res;

    always_comb begin
        fa       = {{W{a_neg}}, SrcA};
        fb       = {{W{b_neg}}, SrcB};
        fprod    = fa * fb;
        fast_res = (MulCtrl[1:0] == 2'b00) ? fprod[W-1:0] : fprod[2*W-1:W];
        direct   = div_zero | div_ovf | ~MulCtrl[2];
        direct_res = MulCtrl[2] ? special_res : fast_res;
    end
`else
    always_comb begin
        direct     = div_zero | div_ovf;
        direct_res = special_res;
    end
`endif

    // One iteration: acc holds {hi, lo}; multiply keeps the multiplier in lo,
    // divide keeps {remainder, dividend/quotient}.
    logic [W:0]     mul_sum, div_tmp;
    logic           div_ge;
    logic [W-1:0]   div_rem;
    logic [2*W-1:0] mul_nx, div_nx, prod_fix;
    logic [W-1:0]   div_sel, fin_res;

    always_comb begin
        mul_sum  = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
        mul_nx   = {mul_sum, acc_q[W-1:1]};
        div_tmp  = acc_q[2*W-1:W-1];
        div_ge   = (div_tmp >= {1'b0, opnd_q});
        div_rem  = div_ge ? (div_tmp[W-1:0] - opnd_q) : div_tmp[W-1:0];
        div_nx   = {div_rem, acc_q[W-2:0], div_ge};
        prod_fix = neg2_if(mul_nx, neg_q);
        div_sel  = neg_if(op_q[1] ? div_nx[2*W-1:W] : div_nx[W-1:0], neg_q);
        if (op_q[2])
            fin_res = div_sel;
        else if (op_q[1:0] == 2'b00)
            fin_res = prod_fix[W-1:0];
        else
            fin_res = prod_fix[2*W-1:W];
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        opnd_d  = opnd_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        neg_d   = neg_q;
        res_d   = res_q;
        if (kill) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_BUSY: begin
                    acc_d = op_q[2] ? div_nx : mul_nx;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == LAST_CNT) begin
                        state_d = ST_DONE;
                        res_d   = fin_res;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    if (start) begin
                        op_d = MulCtrl;
                        if (direct) begin
                            state_d = ST_DONE;
                            res_d   = direct_res;
                        end else begin
                            state_d = ST_BUSY;
                            opnd_d  = MulCtrl[2] ? mag_b : mag_a;
                            acc_d   = {{W{1'b0}}, (MulCtrl[2] ? mag_a : mag_b)};
                            cnt_d   = '0;
                            neg_d   = start_neg;
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            op_q    <= '0;
            opnd_q  <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            neg_q   <= 1'b0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            opnd_q  <= opnd_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            neg_q   <= neg_d;
            res_q   <= res_d;
        end
    end

    assign busy   = (state_q == ST_BUSY);
    assign done   = (state_q == ST_DONE);
    assign Result = res_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed-vector bench for muldiv_unit: results, latency, busy duration, kill, back-to-back, reset.
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [2:0]  MulCtrl;
    logic [31:0] SrcA, SrcB;
    logic        kill;
    logic        busy, done;
    logic [31:0] Result;

    int n_checks = 0;
    int n_fail   = 0;

`ifdef MULDIV_FAST_MUL_EN
    localparam int MUL_LAT  = 1;
    localparam int MUL_BUSY = 0;
`else
    localparam int MUL_LAT  = 33;
    localparam int MUL_BUSY = 32;
`endif

    muldiv_unit #(.DATA_WIDTH(32)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .MulCtrl (MulCtrl),
        .SrcA    (SrcA),
        .SrcB    (SrcB),
        .kill    (kill),
        .busy    (busy),
        .done    (done),
        .Result  (Result)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Presents an operation mid-cycle; returns #1 after the sampling edge k (cycle k+1).
    task automatic start_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        start   = 1'b1;
        MulCtrl = op;
        SrcA    = a;
        SrcB    = b;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Waits (bounded) for done, counting busy cycles; checks latency, busy count and result.
    task automatic wait_done(input string tag, input int exp_lat, input int exp_busy,
                             input logic [31:0] exp_res);
        int n = 1;
        int nb = 0;
        while (!done && n < 60) begin
            nb += int'(busy);
            @(posedge clk);
            #1;
            n++;
        end
        check({tag, "_lat"},  32'(n),  32'(exp_lat));
        check({tag, "_busy"}, 32'(nb), 32'(exp_busy));
        check({tag, "_res"},  Result,  exp_res);
    endtask

    // Cycle after done: pulse must have dropped and the result must be held.
    task automatic after_done(input string tag, input logic [31:0] exp_res);
        @(posedge clk);
        #1;
        check({tag, "_drop"}, {31'b0, done}, 32'd0);
        check({tag, "_hold"}, Result, exp_res);
    endtask

    task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input int lat, input int nbusy,
                          input logic [31:0] exp_res);
        start_op(op, a, b);
        wait_done(tag, lat, nbusy, exp_res);
        after_done(tag, exp_res);
    endtask

    initial begin
        int pulses;
        rst_n   = 1'b0;
        start   = 1'b0;
        kill    = 1'b0;
        MulCtrl = 3'b000;
        SrcA    = '0;
        SrcB    = '0;
        #3;
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_done", {31'b0, done}, 32'd0);
        check("rst_res",  Result, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        run_op("mul",    3'b000, 32'd7,         32'hFFFF_FFFD, MUL_LAT, MUL_BUSY, 32'hFFFF_FFEB);
        run_op("mulh",   3'b001, 32'h8000_0000, 32'h8000_0000, MUL_LAT, MUL_BUSY, 32'h4000_0000);
        run_op("mulhsu", 3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, MUL_LAT, MUL_BUSY, 32'hFFFF_FFFF);
        run_op("mulhu",  3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, MUL_LAT, MUL_BUSY, 32'hFFFF_FFFE);

        run_op("div",    3'b100, 32'hFFFF_FFF9, 32'd2, 33, 32, 32'hFFFF_FFFD);
        run_op("rem",    3'b110, 32'hFFFF_FFF9, 32'd2, 33, 32, 32'hFFFF_FFFF);
        run_op("divu",   3'b101, 32'd100,       32'd7, 33, 32, 32'd14);
        run_op("remu",   3'b111, 32'd100,       32'd7, 33, 32, 32'd2);

        run_op("div0",   3'b100, 32'd5,         32'd0,         1, 0, 32'hFFFF_FFFF);
        run_op("rem0",   3'b110, 32'd5,         32'd0,         1, 0, 32'd5);
        run_op("divovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 1, 0, 32'h8000_0000);
        run_op("removf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 1, 0, 32'd0);

        run_op("divu2",  3'b101, 32'd1000,      32'd10, 33, 32, 32'd100);

        // Kill at cycle k+10 of a DIVU: no done, result keeps 100.
        start_op(3'b101, 32'd200, 32'd3);
        repeat (9) @(posedge clk);
        #1;
        check("kill_busy_before", {31'b0, busy}, 32'd1);
        kill = 1'b1;
        @(posedge clk);
        #1;
        kill = 1'b0;
        check("kill_busy", {31'b0, busy}, 32'd0);
        check("kill_done", {31'b0, done}, 32'd0);
        pulses = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            pulses += int'(done) + int'(busy);
        end
        check("kill_quiet", 32'(pulses), 32'd0);
        check("kill_res",   Result, 32'd100);

        // start together with kill: dropped.
        kill = 1'b1;
        start_op(3'b100, 32'd5, 32'd0);
        kill = 1'b0;
        check("sk_busy", {31'b0, busy}, 32'd0);
        check("sk_done", {31'b0, done}, 32'd0);
        @(posedge clk);
        #1;
        check("sk_done2", {31'b0, done}, 32'd0);
        check("sk_res",   Result, 32'd100);

        // Back-to-back: DIV issued in the DONE cycle of a MUL.
        start_op(3'b000, 32'd6, 32'd7);
        wait_done("b2b_mul", MUL_LAT, MUL_BUSY, 32'd42);
        start_op(3'b100, 32'd100, 32'hFFFF_FFFB);
        check("b2b_drop", {31'b0, done}, 32'd0);
        check("b2b_busy", {31'b0, busy}, 32'd1);
        wait_done("b2b_div", 33, 32, 32'hFFFF_FFEC);
        after_done("b2b_div", 32'hFFFF_FFEC);

        // Asynchronous reset in the middle of an iterative divide.
        start_op(3'b101, 32'd77, 32'd5);
        repeat (4) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_busy", {31'b0, busy}, 32'd0);
        check("arst_done", {31'b0, done}, 32'd0);
        check("arst_res",  Result, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        check("arst_idle", {31'b0, done}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative RV32M multiply/divide execution unit for the RV32IM core. It sits beside the ALU in the execute stage and consumes the decoder's `Mul` indication together with `funct3` (`Instr[14:12]`). It accepts one operation per start pulse and reports completion with a one-cycle `done` pulse. The result is held until the next accepted operation, so the hazard logic can stall the pipeline on `busy`.

## Interface
Parameters:
- `DATA_WIDTH`, default 32: operand and result width.

Ports:
- `clk`, in, 1: clock; all state updates on the rising edge.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `start`, in, 1: request a new operation; sampled on the rising edge.
- `MulCtrl`, in, 3: `funct3` of the M instruction; captured on start.
- `SrcA`, in, `DATA_WIDTH`: rs1 operand (multiplicand or dividend); captured on start.
- `SrcB`, in, `DATA_WIDTH`: rs2 operand (multiplier or divisor); captured on start.
- `kill`, in, 1: pipeline flush; aborts any operation in flight.
- `busy`, out, 1: high while an operation is iterating.
- `done`, out, 1: one-cycle pulse when `Result` becomes valid.
- `Result`, out, `DATA_WIDTH`: operation result; held until the next accepted start.

## Operation
`MulCtrl` encoding:
- `000` MUL: low word of the product.
- `001` MULH: high word, signed × signed.
- `010` MULHSU: high word, signed `SrcA` × unsigned `SrcB`.
- `011` MULHU: high word, unsigned × unsigned.
- `100` DIV, `101` DIVU, `110` REM, `111` REMU.

State machine: IDLE, BUSY, DONE.
- IDLE/DONE → BUSY on `start & !kill`, normal case.
  - On that edge, capture `MulCtrl` and load the magnitudes of the signed operands.
  - Record the result sign: XOR of the operand signs for products and quotients; dividend sign for remainders.
  - Clear the iteration counter.
- IDLE/DONE → DONE directly on `start & !kill` for the special divide cases. `Result` is loaded on that edge:
  - Divisor zero: DIV/DIVU → all ones; REM/REMU → `SrcA`.
  - Signed overflow, DIV with `SrcA` = 0x80000000 and `SrcB` = −1 → 0x80000000; REM → 0.
- BUSY: one iteration per cycle.
  - Multiply: shift-add into a `2*DATA_WIDTH` accumulator.
  - Divide: restoring; shift the remainder, conditionally subtract, shift in the quotient bit.
  - After iteration `DATA_WIDTH-1`, apply the sign fix (two's complement of the `2*DATA_WIDTH` product or of the quotient/remainder), load `Result`, go to DONE.
- DONE: `done`=1 for exactly this cycle. Next state is BUSY/DONE if a new start is accepted, else IDLE.
- `kill` in any state: next state IDLE, `done` not asserted, `Result` unchanged.
- `start` while BUSY is ignored; the operation in flight is not disturbed.
- `start` and `kill` in the same cycle: `kill` wins and the start is dropped.

Outputs:
- `busy` = (state == BUSY).
- `done` = (state == DONE).
- `Result` is a register.

## Timing
- Reset (`rst_n` low, asynchronous): state IDLE, `busy`=0, `done`=0, `Result`=0, counter 0, captured operands 0.
- Reset asserted mid-operation: abort immediately, with no `done`.
- Iterative operation with start sampled at edge k:
  - `busy`=1 during cycles k+1 … k+`DATA_WIDTH`.
  - `done`=1 and `Result` valid in cycle k+`DATA_WIDTH`+1. For 32 bits that is 33 cycles.
- Special divide case: `done` in cycle k+1.
- Back-to-back: a start asserted during the DONE cycle is accepted. `done` drops the next cycle and `busy` rises.
- `Result` never changes except on the cycle entering DONE, or on reset.

## Configuration
- `MULDIV_FAST_MUL_EN` defined:
  - All four multiply encodings compute with a single-cycle `2*DATA_WIDTH` signed/unsigned product on the start edge and go IDLE/DONE → DONE directly. `done` arrives in cycle k+1 and `busy` never rises for multiplies.
  - Divides are unchanged.
- Undefined: multiplies use the iterative BUSY path with the latency above.

## Test plan
- MUL, `SrcA`=7, `SrcB`=−3 (0xFFFFFFFD) → `Result`=0xFFFFFFEB; `done` at cycle k+33, or k+1 with `MULDIV_FAST_MUL_EN`.
- MULH, 0x80000000 × 0x80000000 → 0x40000000. MULHSU, −1 × 0xFFFFFFFF → 0xFFFFFFFF. MULHU, 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE.
- DIV −7/2 → 0xFFFFFFFD; REM −7/2 → 0xFFFFFFFF; DIVU 100/7 → 14; REMU 100/7 → 2; each with `done` at k+33 and `busy` high for 32 cycles.
- Divide by zero, DIV 5/0 → 0xFFFFFFFF, REM 5/0 → 5; overflow DIV 0x80000000/−1 → 0x80000000, REM → 0; `done` at k+1 and `busy` never high.
- `kill` at cycle k+10 of a DIVU → IDLE next cycle, no `done`, `Result` keeps its previous value. `start`+`kill` together → no operation starts.
- Start during DONE (back-to-back MUL then DIV) → second result correct, with exactly one `done` pulse each. `rst_n` low mid-BUSY → all outputs 0 immediately.
